// File: rtl/aximm_arb_pkg.sv
// Shared types and constants for the AXIMM leader arbiter.
package aximm_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B   = 3'd4;

    // Widest address any instance may use; narrower instances zero-extend.
    localparam int CMD_ADDR_MAX = 64;

    typedef struct packed {
        logic                    is_wr;
        logic [CMD_ADDR_MAX-1:0] addr;
        logic [7:0]              len;
    } cmd_t;

endpackage

// File: rtl/aximm_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module aximm_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    idx,
    output logic               any
);

    logic [IDXW:0] cand;

    // Walk from the farthest candidate back toward ptr so the nearest one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDXW + 1)'(k);
            if (cand >= (IDXW + 1)'(NUM_REQ)) begin
                cand = cand - (IDXW + 1)'(NUM_REQ);
            end
            if (req[cand[IDXW-1:0]]) begin
                grant                 = '0;
                grant[cand[IDXW-1:0]] = 1'b1;
                idx                   = cand[IDXW-1:0];
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aximm_leader_arbiter.sv
// Round-robin sequencer sharing one AXIMM leader between NUM_REQ requesters.
// Optional WAIT watchdog is enabled by defining AXIMM_ARB_TIMEOUT_EN.
module aximm_leader_arbiter
    import aximm_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDRWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_is_wr,
    input  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]         req_len,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         req_err,
    output logic                         axi_wr,
    output logic                         axi_rd,
    output logic [ADDRWIDTH-1:0]         axi_rw_addr,
    output logic [7:0]                   axi_rw_length,
    output logic [1:0]                   axi_rw_burst,
    output logic [2:0]                   axi_rw_size,
    input  logic                         wr_done,
    input  logic                         rd_done,
    output logic                         busy,
    output logic [15:0]                  wr_count,
    output logic [15:0]                  rd_count
);

    localparam int IDXW = $clog2(NUM_REQ);

    arb_state_t         state;
    cmd_t               cmd_q;
    logic [IDXW-1:0]    idx_q;
    logic [IDXW-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_any;
    logic               wait_match;
    logic               unused_cmd_addr;

`ifdef AXIMM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
`endif

    aximm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Only a completion of the type we issued counts; the other kind is noise.
    assign wait_match      = cmd_q.is_wr ? wr_done : rd_done;
    assign axi_rw_addr     = cmd_q.addr[ADDRWIDTH-1:0];
    assign axi_rw_length   = cmd_q.len;
    assign axi_rw_burst    = AXI_BURST_INCR;
    assign axi_rw_size     = AXI_SIZE_16B;
    assign unused_cmd_addr = ^cmd_q.addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= '0;
            idx_q     <= '0;
            rr_ptr    <= '0;
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            axi_wr    <= 1'b0;
            axi_rd    <= 1'b0;
            busy      <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
`ifdef AXIMM_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            axi_wr    <= 1'b0;
            axi_rd    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx_q       <= pick_idx;
                        cmd_q.is_wr <= req_is_wr[pick_idx];
                        cmd_q.addr  <= CMD_ADDR_MAX'(req_addr[int'(pick_idx)*ADDRWIDTH +: ADDRWIDTH]);
                        cmd_q.len   <= req_len[int'(pick_idx)*8 +: 8];
                        req_ready   <= pick_grant;
                        busy        <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // The leader cannot run a zero-length burst, so reject it here.
                    if (cmd_q.len == 8'd0) begin
                        req_done <= NUM_REQ'(1) << idx_q;
                        req_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        axi_wr <= cmd_q.is_wr;
                        axi_rd <= ~cmd_q.is_wr;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef AXIMM_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_match) begin
                        if (cmd_q.is_wr) begin
                            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                        end else begin
                            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                        end
                        req_done <= NUM_REQ'(1) << idx_q;
                        state    <= DONE;
                    end
`ifdef AXIMM_ARB_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        req_done <= NUM_REQ'(1) << idx_q;
                        req_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    rr_ptr <= (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_leader_arbiter.sv
// Self-checking bench for aximm_leader_arbiter: vector table, hand sequences, random traffic.
module tb_aximm_leader_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_is_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*8-1:0]  req_len = '0;
    logic [N-1:0]    req_ready, req_done;
    logic            req_err, axi_wr, axi_rd, busy;
    logic            wr_done = 1'b0;
    logic            rd_done = 1'b0;
    logic [AW-1:0]   axi_rw_addr;
    logic [7:0]      axi_rw_length;
    logic [1:0]      axi_rw_burst;
    logic [2:0]      axi_rw_size;
    logic [15:0]     wr_count, rd_count;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    int model_wr  = 0;
    int model_rd  = 0;

    typedef struct {
        logic [N-1:0]   valid;
        logic [N-1:0]   is_wr;
        logic [N*8-1:0] lens;
        int             exp_idx;
        logic           exp_err;
        bit             wrong;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    aximm_leader_arbiter #(
        .NUM_REQ        (N),
        .ADDRWIDTH      (AW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_is_wr     (req_is_wr),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .req_done      (req_done),
        .req_err       (req_err),
        .axi_wr        (axi_wr),
        .axi_rd        (axi_rd),
        .axi_rw_addr   (axi_rw_addr),
        .axi_rw_length (axi_rw_length),
        .axi_rw_burst  (axi_rw_burst),
        .axi_rw_size   (axi_rw_size),
        .wr_done       (wr_done),
        .rd_done       (rd_done),
        .busy          (busy),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] w,
                                 input logic [N*AW-1:0] a, input logic [N*8-1:0] l);
        req_valid = v;
        req_is_wr = w;
        req_addr  = a;
        req_len   = l;
    endtask

    function automatic logic [N*AW-1:0] tableAddrs(input int k);
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) a[i*AW +: AW] = 32'h1000 + 32'(i) * 32'h100 + 32'(k) * 32'h10;
        return a;
    endfunction

    // Winner is the valid requester with the smallest forward distance from the pointer.
    function automatic int pickModel(input logic [N-1:0] v, input int ptr);
        int best = -1;
        int best_dist = N;
        for (int j = 0; j < N; j++) begin
            if (v[j] && ((j - ptr + N) % N) < best_dist) begin
                best_dist = (j - ptr + N) % N;
                best = j;
            end
        end
        return best;
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_ptr = 0;
        model_wr  = 0;
        model_rd  = 0;
    endtask

    task automatic waitReady(output bit ok);
        int waited = 0;
        while (req_ready == '0 && waited < 20) begin
            step();
            waited++;
        end
        ok = (req_ready != '0);
        if (!ok) begin
            n_checks++;
            $display("[TB] FAIL grant_timeout: got no req_ready, expected one within 20 cycles");
        end
    endtask

    task automatic doCommand(input int exp_idx, input logic exp_err, input bit drop,
                             input int delay, input bit wrong);
        logic         exp_wr;
        logic [AW-1:0] exp_addr;
        logic [7:0]   exp_len;
        logic [N-1:0] onehot;
        bit           ok;
        exp_wr   = req_is_wr[exp_idx];
        exp_addr = req_addr[exp_idx*AW +: AW];
        exp_len  = req_len[exp_idx*8 +: 8];
        onehot   = N'(1) << exp_idx;
        waitReady(ok);
        if (!ok) return;
        checkOutput("req_ready", req_ready, onehot);
        checkOutput("busy_grant", busy, 1);
        if (drop) applyStimulus('0, ~req_is_wr, ~req_addr, ~req_len);
        step();
        if (exp_err) begin
            checkOutput("zero_len_done", req_done, onehot);
            checkOutput("zero_len_err", req_err, 1);
            checkOutput("zero_len_no_strobe", {axi_wr, axi_rd}, 2'b00);
        end else begin
            checkOutput("strobe_wr", axi_wr, exp_wr);
            checkOutput("strobe_rd", axi_rd, !exp_wr);
            checkOutput("rw_addr", axi_rw_addr, exp_addr);
            checkOutput("rw_length", axi_rw_length, exp_len);
            step();
            checkOutput("strobe_pulse", {axi_wr, axi_rd}, 2'b00);
            repeat (delay) step();
            if (wrong) begin
                if (exp_wr) rd_done = 1'b1;
                else wr_done = 1'b1;
                step();
                wr_done = 1'b0;
                rd_done = 1'b0;
                checkOutput("wrong_type_ignored", req_done, 0);
            end
            if (exp_wr) wr_done = 1'b1;
            else rd_done = 1'b1;
            step();
            wr_done = 1'b0;
            rd_done = 1'b0;
            if (exp_wr && model_wr < 65535) model_wr++;
            if (!exp_wr && model_rd < 65535) model_rd++;
            checkOutput("req_done", req_done, onehot);
            checkOutput("req_err", req_err, 0);
            checkOutput("wr_count", wr_count, model_wr);
            checkOutput("rd_count", rd_count, model_rd);
            checkOutput("rw_addr_held", axi_rw_addr, exp_addr);
        end
        model_ptr = (exp_idx + 1) % N;
        step();
        checkOutput("busy_idle", busy, 0);
        checkOutput("req_done_pulse", req_done, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N*AW-1:0] ra;
        logic [N*8-1:0]  rl;
        logic [N-1:0]    rv;
        int              idx;
        bit              ok;

        vecs[0]  = '{4'b0001, 4'b0001, 32'h00000008, 0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0101, 32'h04040404, 1, 1'b0, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0101, 32'h04040404, 2, 1'b0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0101, 32'h04040404, 3, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0101, 32'h04040404, 0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0001, 4'b0000, 32'h00000010, 0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 4'b0100, 32'h01000203, 2, 1'b1, 1'b0};
        vecs[7]  = '{4'b1000, 4'b1000, 32'h01000000, 3, 1'b0, 1'b0};
        vecs[8]  = '{4'b0110, 4'b0010, 32'h00202000, 1, 1'b0, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0001, 32'h00000303, 0, 1'b0, 1'b0};
        vecs[10] = '{4'b1010, 4'b1000, 32'hFF001100, 1, 1'b0, 1'b0};
        vecs[11] = '{4'b1010, 4'b1000, 32'hFF001100, 3, 1'b0, 1'b0};

        $display("[TB] reset state");
        applyStimulus('0, '0, '0, '0);
        repeat (3) step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_done", req_done, 0);
        checkOutput("rst_err", req_err, 0);
        checkOutput("rst_strobes", {axi_wr, axi_rd}, 2'b00);
        checkOutput("rst_addr", axi_rw_addr, 0);
        checkOutput("rst_len", axi_rw_length, 0);
        checkOutput("rst_burst", axi_rw_burst, 2'b01);
        checkOutput("rst_size", axi_rw_size, 3'd4);
        checkOutput("rst_wr_count", wr_count, 0);
        checkOutput("rst_rd_count", rd_count, 0);
        rst_n = 1'b1;
        step();
        checkOutput("idle_no_req", busy, 0);

        $display("[TB] rotation with all requesters valid");
        applyStimulus(4'b1111, 4'b0101, tableAddrs(7), 32'h05060708);
        for (int r = 0; r < 5; r++) begin
            doCommand(r % N, 1'b0, (r == 4), 1, 1'b0);
            if (r == 3) begin
                checkOutput("rot_wr_count", wr_count, 2);
                checkOutput("rot_rd_count", rd_count, 2);
            end
        end

        $display("[TB] vector table");
        doReset();
        step();
        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k].valid, vecs[k].is_wr, tableAddrs(k), vecs[k].lens);
            doCommand(vecs[k].exp_idx, vecs[k].exp_err, 1'b1, k % 3, vecs[k].wrong);
        end

        $display("[TB] reset in the middle of a burst");
        applyStimulus(4'b0010, 4'b0000, tableAddrs(20), 32'h04040404);
        step();
        checkOutput("mid_ready", req_ready, 4'b0010);
        applyStimulus('0, '0, '0, '0);
        step();
        step();
        checkOutput("mid_busy_wait", busy, 1);
        rst_n = 1'b0;
        applyStimulus(4'b0100, 4'b0100, tableAddrs(21), 32'h04040404);
        step();
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", req_done, 0);
        checkOutput("mid_rst_wr_count", wr_count, 0);
        checkOutput("mid_rst_rd_count", rd_count, 0);
        rst_n = 1'b1;
        model_ptr = 0;
        model_wr  = 0;
        model_rd  = 0;
        doCommand(2, 1'b0, 1'b1, 1, 1'b0);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 40; t++) begin
            rv = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ra[i*AW +: AW] = $urandom;
                rl[i*8 +: 8]   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            applyStimulus(rv, N'($urandom), ra, rl);
            idx = pickModel(rv, model_ptr);
            doCommand(idx, (rl[idx*8 +: 8] == 8'd0), 1'b1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

`ifdef AXIMM_ARB_TIMEOUT_EN
        $display("[TB] watchdog timeout in WAIT");
        begin
            int cycles = 0;
            applyStimulus(4'b0001, 4'b0001, tableAddrs(30), 32'h00000008);
            idx = pickModel(4'b0001, model_ptr);
            waitReady(ok);
            if (ok) begin
                checkOutput("to_ready", req_ready, N'(1) << idx);
                applyStimulus('0, '0, '0, '0);
                step();
                step();
                while (req_done == '0 && cycles < 40) begin
                    step();
                    cycles++;
                end
                checkOutput("to_cycles", cycles, 16);
                checkOutput("to_done", req_done, 4'b0001);
                checkOutput("to_err", req_err, 1);
                checkOutput("to_wr_count", wr_count, model_wr);
                model_ptr = (idx + 1) % N;
                step();
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aximm_leader_arbiter.md
Name: aximm_leader_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AXIMM leader application between NUM_REQ requesters.
- Each requester posts a write or read burst command (addr, length).
- The block grants one command at a time, pulses the leader's axi_wr/axi_rd start strobes, holds the command fields stable, and waits for burst completion.
- On completion it returns a done pulse to the owning requester.
- Sits between the traffic/test sources and the leader app, above the AXI4-MM link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDRWIDTH, 32, AXI address width; must match the leader app.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with AXIMM_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  single clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester command pending
- req_is_wr  input  NUM_REQ  1=write burst, 0=read burst
- req_addr  input  NUM_REQ*ADDRWIDTH  packed start addresses; requester i at [i*ADDRWIDTH +: ADDRWIDTH]
- req_len  input  NUM_REQ*8  packed burst lengths; requester i at [i*8 +: 8]
- req_ready  output  NUM_REQ  one-hot, 1-cycle accept pulse
- req_done  output  NUM_REQ  one-hot, 1-cycle completion pulse
- req_err  output  1  qualifies req_done; 1 = rejected or timed out
- axi_wr  output  1  write start strobe to leader
- axi_rd  output  1  read start strobe to leader
- axi_rw_addr  output  ADDRWIDTH  latched command address
- axi_rw_length  output  8  latched command length
- axi_rw_burst  output  2  constant 2'b01 (INCR)
- axi_rw_size  output  3  constant 3'd4
- wr_done  input  1  leader write burst complete (bvalid & bready), pulse
- rd_done  input  1  leader read burst complete (rvalid & rready & rlast), pulse
- busy  output  1  high in any state other than IDLE
- wr_count  output  16  completed write bursts, saturating
- rd_count  output  16  completed read bursts, saturating

Behaviour:

Reset:
- Clock is clk; reset is synchronous and active-low on rst_n.
- All outputs are 0 except axi_rw_burst=2'b01 and axi_rw_size=3'd4.
- State=IDLE, rr_ptr=0, counters=0.

States: IDLE, GRANT, ISSUE, WAIT, DONE.

IDLE:
- If any req_valid is set, select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- Latch the selected requester's index, is_wr, addr and len. Go to GRANT.

GRANT:
- req_ready[idx]=1 for exactly this cycle.
- The requester drops or changes valid/fields after this; the latched copy is used from here on.
- If latched len==0, go to DONE with err=1, and no strobe is issued (the leader cannot process a zero-length burst).
- Otherwise go to ISSUE.

ISSUE:
- axi_wr=is_wr or axi_rd=~is_wr, asserted for exactly 1 cycle.
- axi_rw_addr/axi_rw_length are driven from the latch from GRANT through DONE and held at their last value otherwise.
- Go to WAIT.

WAIT:
- Write command: wait for wr_done. Read command: wait for rd_done.
- A completion pulse of the wrong type is ignored.
- A completion pulse arriving in the same cycle as the strobe is not possible; the strobe precedes WAIT.
- On the matching pulse, increment wr_count or rd_count (saturating at 16'hFFFF). Go to DONE with err=0.

DONE:
- req_done[idx]=1 and req_err=err for 1 cycle.
- rr_ptr=(idx+1) mod NUM_REQ. Return to IDLE.

Latency and throughput:
- Minimum latency is valid to first strobe = 3 cycles (IDLE, GRANT, ISSUE).
- At most one command is outstanding; there is no pipelining.

Other rules:
- req_valid changes outside GRANT have no effect on an in-flight command.
- Simultaneous requests are served in strict rotation, so no requester is starved.
- Reset mid-operation returns to IDLE immediately with no done pulse, and counters clear.

Optional Feature:
- AXIMM_ARB_TIMEOUT_EN defined:
  - A 16-bit cycle counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without the matching done, go to DONE with err=1, and the count is not incremented.
  - A completion arriving on the timeout cycle takes priority (err=0).
- Not defined: WAIT blocks indefinitely, and no counter logic is synthesised.

Decomposition:
- Shared package aximm_arb_pkg:
  - state enum (IDLE/GRANT/ISSUE/WAIT/DONE)
  - AXI_BURST_INCR=2'b01
  - AXI_SIZE_16B=3'd4
  - command struct {is_wr, addr, len}
- One sub-module, aximm_rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> one-hot grant + index).

Test Plan:
- Single write: req_valid[0]=1, is_wr=1, addr=32'h1000, len=8 -> req_ready[0] 1 cycle later; axi_wr 1-cycle pulse with axi_rw_addr=32'h1000, axi_rw_length=8; wr_done -> req_done[0], req_err=0, wr_count=1.
- Rotation: all 4 requesters valid continuously with is_wr alternating -> grants in order 0,1,2,3,0; each strobe follows the previous req_done; rd_count and wr_count each reach 2 after 4 completions.
- Wrong completion type: read pending, wr_done pulsed -> stays in WAIT, no done; then rd_done -> req_done, rd_count=1, wr_count unchanged.
- Zero length: req_len[2]=0 -> req_ready[2], no axi_wr/axi_rd pulse, req_done[2] with req_err=1 two cycles later.
- Reset mid-burst: assert rst_n=0 while in WAIT -> next cycle busy=0, no req_done, counters=0; the new request is served normally afterwards.
- AXIMM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: write issued, no wr_done -> req_done with req_err=1 exactly 16 cycles after entering WAIT; wr_count stays 0.
